// File: rtl/synth_pkg.sv
// Shared widths, event/state encodings and the per-voice state record used by the voice allocator.
package synth_pkg;

    localparam int NOTE_W    = 7;
    localparam int VEL_W     = 7;
    // Ages are zero-extended to this width for comparison, so AGE_W must not exceed it.
    localparam int MAX_AGE_W = 16;

    typedef enum logic [1:0] {
        EV_NOTE_OFF = 2'b00,
        EV_NOTE_ON  = 2'b01,
        EV_ALL_OFF  = 2'b10,
        EV_RESERVED = 2'b11
    } ev_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCAN   = 2'b01,
        ST_COMMIT = 2'b10
    } alloc_state_e;

    // Higher value wins; equal released/steal ranks are broken by age.
    typedef enum logic [2:0] {
        RANK_NONE     = 3'd0,
        RANK_STEAL    = 3'd1,
        RANK_RELEASED = 3'd2,
        RANK_FREE     = 3'd3,
        RANK_RETRIG   = 3'd4
    } cand_rank_e;

    typedef struct packed {
        logic                 gate;
        logic [NOTE_W-1:0]    note;
        logic [VEL_W-1:0]     vel;
        logic [MAX_AGE_W-1:0] age;
    } voice_state_t;

    function automatic cand_rank_e classify(input voice_state_t vs,
                                            input logic env_idle,
                                            input logic [NOTE_W-1:0] note);
        cand_rank_e rank;
        if (vs.gate && (vs.note == note)) begin
            rank = RANK_RETRIG;
        end else if (!vs.gate && env_idle) begin
            rank = RANK_FREE;
        end else if (!vs.gate) begin
            rank = RANK_RELEASED;
        end else begin
            rank = RANK_STEAL;
        end
        return rank;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters: on each update the selected voice restarts at zero
// and every other voice ages by one.
module voice_age_tracker
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd,
    input  logic [IDX_W-1:0]            sel,
    output logic [NUM_VOICES*AGE_W-1:0] ages
);

    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [AGE_W-1:0] age_r [NUM_VOICES];

    // Age registers: clear selected, saturating increment for the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_r[i] <= {AGE_W{1'b0}};
            end
        end else if (upd) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == sel) begin
                    age_r[i] <= {AGE_W{1'b0}};
                end else if (age_r[i] != AGE_MAX) begin
                    age_r[i] <= age_r[i] + AGE_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign ages[g*AGE_W +: AGE_W] = age_r[g];
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-event to voice-slot allocator: a serial scan picks the best voice for each
// NOTE_ON (retrigger > free > oldest released > oldest gated), then commits in one cycle.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic [1:0]                   ev_type,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [VEL_W-1:0]             ev_vel,
    input  logic [NUM_VOICES-1:0]        env_idle,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
    output logic                         steal
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    alloc_state_e             state_r;
    alloc_state_e             state_s;
    logic                     ready_r;
    logic                     accept_s;

    ev_type_e                 ev_type_r;
    logic [NOTE_W-1:0]        ev_note_r;
    logic [VEL_W-1:0]         ev_vel_r;

    logic [IDX_W-1:0]         scan_idx_r;
    cand_rank_e               best_rank_r;
    logic [IDX_W-1:0]         best_idx_r;
    logic [MAX_AGE_W-1:0]     best_age_r;
    voice_state_t             cur_s;
    cand_rank_e               rank_s;
    logic                     better_s;

    logic [NUM_VOICES-1:0]    gate_r;
    logic [NUM_VOICES-1:0]    trig_r;
    logic                     steal_r;
    logic [NOTE_W-1:0]        note_r [NUM_VOICES];
    logic [VEL_W-1:0]         vel_r  [NUM_VOICES];
    voice_state_t             vs_s   [NUM_VOICES];

    logic                     age_upd_s;
    logic [NUM_VOICES*AGE_W-1:0] ages_s;

    // rst masks ready combinationally so it is low during reset and high right after.
    assign ev_ready  = ready_r & ~rst;
    assign accept_s  = ev_valid & ev_ready;
    assign age_upd_s = (state_r == ST_COMMIT) && (ev_type_r == EV_NOTE_ON);

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W)
    ) u_age (
        .clk  (clk),
        .rst  (rst),
        .upd  (age_upd_s),
        .sel  (best_idx_r),
        .ages (ages_s)
    );

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        assign vs_s[g] = '{gate: gate_r[g],
                           note: note_r[g],
                           vel:  vel_r[g],
                           age:  MAX_AGE_W'(ages_s[g*AGE_W +: AGE_W])};
        assign voice_gate[g]                 = vs_s[g].gate;
        assign voice_note[g*NOTE_W +: NOTE_W] = vs_s[g].note;
        assign voice_vel[g*VEL_W +: VEL_W]    = vs_s[g].vel;
    end

    assign voice_trig = trig_r;
    assign steal      = steal_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: only NOTE_ON/NOTE_OFF need the voice scan.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((ev_type == EV_NOTE_ON) || (ev_type == EV_NOTE_OFF)) begin
                        state_s = ST_SCAN;
                    end else begin
                        state_s = ST_COMMIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_idx_r == IDX_W'(NUM_VOICES - 1)) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Ready flag registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= (state_s == ST_IDLE);
        end
    end

    // Scan comparator: rank the voice under the scan pointer against the running best.
    always_comb begin
        cur_s  = vs_s[scan_idx_r];
        rank_s = classify(cur_s, env_idle[scan_idx_r], ev_note_r);
        if (rank_s > best_rank_r) begin
            better_s = 1'b1;
        end else if ((rank_s == best_rank_r) &&
                     ((rank_s == RANK_RELEASED) || (rank_s == RANK_STEAL)) &&
                     (cur_s.age > best_age_r)) begin
            better_s = 1'b1;
        end else begin
            better_s = 1'b0;
        end
    end

    // Event capture, scan bookkeeping and voice output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_type_r   <= EV_RESERVED;
            ev_note_r   <= {NOTE_W{1'b0}};
            ev_vel_r    <= {VEL_W{1'b0}};
            scan_idx_r  <= {IDX_W{1'b0}};
            best_rank_r <= RANK_NONE;
            best_idx_r  <= {IDX_W{1'b0}};
            best_age_r  <= {MAX_AGE_W{1'b0}};
            gate_r      <= {NUM_VOICES{1'b0}};
            trig_r      <= {NUM_VOICES{1'b0}};
            steal_r     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= {NOTE_W{1'b0}};
                vel_r[i]  <= {VEL_W{1'b0}};
            end
        end else begin
            trig_r  <= {NUM_VOICES{1'b0}};
            steal_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // A zero-velocity NOTE_ON is a NOTE_OFF in MIDI.
                        if ((ev_type == EV_NOTE_ON) && (ev_vel == {VEL_W{1'b0}})) begin
                            ev_type_r <= EV_NOTE_OFF;
                        end else begin
                            ev_type_r <= ev_type_e'(ev_type);
                        end
                        ev_note_r   <= ev_note;
                        ev_vel_r    <= ev_vel;
                        scan_idx_r  <= {IDX_W{1'b0}};
                        best_rank_r <= RANK_NONE;
                        best_idx_r  <= {IDX_W{1'b0}};
                        best_age_r  <= {MAX_AGE_W{1'b0}};
                    end
                end
                ST_SCAN: begin
                    scan_idx_r <= scan_idx_r + IDX_W'(1);
                    if (better_s) begin
                        best_rank_r <= rank_s;
                        best_idx_r  <= scan_idx_r;
                        best_age_r  <= cur_s.age;
                    end
                end
                ST_COMMIT: begin
                    case (ev_type_r)
                        EV_NOTE_ON: begin
                            gate_r[best_idx_r] <= 1'b1;
                            note_r[best_idx_r] <= ev_note_r;
                            vel_r[best_idx_r]  <= ev_vel_r;
                            trig_r             <= NUM_VOICES'(1) << best_idx_r;
                            steal_r            <= (best_rank_r == RANK_STEAL);
                        end
                        EV_NOTE_OFF: begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (gate_r[i] && (note_r[i] == ev_note_r)) begin
                                    gate_r[i] <= 1'b0;
                                end
                            end
                        end
                        EV_ALL_OFF: gate_r <= {NUM_VOICES{1'b0}};
                        default:    gate_r <= gate_r;
                    endcase
                end
                default: scan_idx_r <= {IDX_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, multi-cycle corner
// sequences and random events checked against a behavioural voice-pool model.
module tb_voice_allocator;

    localparam int NV      = 8;
    localparam int AGE_MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic [1:0]    ev_type = 2'b00;
    logic [6:0]    ev_note = 7'd0;
    logic [6:0]    ev_vel  = 7'd0;
    logic [NV-1:0] env_idle = 8'hff;
    logic [NV-1:0] voice_gate;
    logic [NV-1:0] voice_trig;
    logic [NV*7-1:0] voice_note;
    logic [NV*7-1:0] voice_vel;
    logic          steal;

    int n_checks = 0;
    int n_fail   = 0;

    int            m_gate [NV];
    int            m_note [NV];
    int            m_vel  [NV];
    int            m_age  [NV];
    logic [NV-1:0] m_trig;
    logic          m_steal;

    typedef struct {
        logic [1:0] t;
        logic [6:0] n;
        logic [6:0] v;
        logic [7:0] idle;
        logic [7:0] eg;
        logic [7:0] et;
        logic       es;
    } vec_t;
    vec_t tbl [19];

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_type    (ev_type),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .env_idle   (env_idle),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .steal      (steal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_trig = '0;
        m_steal = 1'b0;
    endfunction

    // Voice pool model: policy expressed as successive searches over the pool.
    function automatic void model_apply(input int t, input int n, input int v, input logic [NV-1:0] idle);
        int pick;
        int best;
        m_trig = '0;
        m_steal = 1'b0;
        if (t == 1 && v == 0) t = 0;
        if (t == 1) begin
            pick = -1;
            for (int i = 0; i < NV; i++)
                if (pick < 0 && m_gate[i] == 1 && m_note[i] == n) pick = i;
            for (int i = 0; i < NV; i++)
                if (pick < 0 && m_gate[i] == 0 && idle[i]) pick = i;
            if (pick < 0) begin
                best = -1;
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] == 0 && !idle[i] && m_age[i] > best) begin
                        best = m_age[i]; pick = i;
                    end
            end
            if (pick < 0) begin
                best = -1;
                m_steal = 1'b1;
                for (int i = 0; i < NV; i++)
                    if (m_age[i] > best) begin
                        best = m_age[i]; pick = i;
                    end
            end
            for (int i = 0; i < NV; i++)
                m_age[i] = (i == pick) ? 0 : ((m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX);
            m_gate[pick] = 1;
            m_note[pick] = n;
            m_vel[pick]  = v;
            m_trig[pick] = 1'b1;
        end else if (t == 0) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] == 1 && m_note[i] == n) m_gate[i] = 0;
        end else if (t == 2) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 0;
        end
    endfunction

    task automatic check_model(input string nm);
        logic [NV-1:0]   eg;
        logic [NV*7-1:0] en;
        logic [NV*7-1:0] ev;
        for (int i = 0; i < NV; i++) begin
            eg[i]        = (m_gate[i] == 1);
            en[i*7 +: 7] = 7'(m_note[i]);
            ev[i*7 +: 7] = 7'(m_vel[i]);
        end
        chk({nm, "_gate"},  64'(voice_gate), 64'(eg));
        chk({nm, "_trig"},  64'(voice_trig), 64'(m_trig));
        chk({nm, "_steal"}, 64'(steal),      64'(m_steal));
        chk({nm, "_note"},  64'(voice_note), 64'(en));
        chk({nm, "_vel"},   64'(voice_vel),  64'(ev));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_low", 64'(ev_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_ready_high", 64'(ev_ready), 64'd1);
        check_model("rst");
    endtask

    // Present one event, then check busy ready, the commit result and the trig/steal pulse width.
    task automatic run_event(input string nm, input logic [1:0] t, input logic [6:0] n, input logic [6:0] v,
                             input logic [7:0] idle, input bit has_exp,
                             input logic [7:0] eg, input logic [7:0] et, input logic es);
        int lat;
        int waited = 0;
        while (!ev_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({nm, "_ready_wait"}, 64'(ev_ready), 64'd1);
        env_idle = idle;
        ev_valid = 1'b1;
        ev_type = t; ev_note = n; ev_vel = v;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        ev_type = 2'($urandom); ev_note = 7'($urandom); ev_vel = 7'($urandom);
        model_apply(int'(t), int'(n), int'(v), idle);
        lat = (t == 2'b00 || t == 2'b01) ? NV + 1 : 1;
        for (int c = 0; c < lat; c++) begin
            chk({nm, "_ready_busy"}, 64'(ev_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk({nm, "_ready_back"}, 64'(ev_ready), 64'd1);
        check_model(nm);
        if (has_exp) begin
            chk({nm, "_tbl_gate"},  64'(voice_gate), 64'(eg));
            chk({nm, "_tbl_trig"},  64'(voice_trig), 64'(et));
            chk({nm, "_tbl_steal"}, 64'(steal),      64'(es));
        end
        @(posedge clk); #1;
        chk({nm, "_trig_pulse"},  64'(voice_trig), 64'd0);
        chk({nm, "_steal_pulse"}, 64'(steal),      64'd0);
    endtask

    initial begin
        int k;
        int cyc;
        int last;
        bit acc;

        // Directed table: fill, steal, retrigger, released/free preference, off variants.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{2'b01, 7'(60 + i), 7'd100, 8'hff, 8'((1 << (i + 1)) - 1), 8'(1 << i), 1'b0};
        tbl[8]  = '{2'b01, 7'd70, 7'd90,  8'hff, 8'hff, 8'h01, 1'b1};
        tbl[9]  = '{2'b01, 7'd62, 7'd50,  8'hff, 8'hff, 8'h04, 1'b0};
        tbl[10] = '{2'b00, 7'd63, 7'd0,   8'h00, 8'hf7, 8'h00, 1'b0};
        tbl[11] = '{2'b00, 7'd65, 7'd0,   8'h00, 8'hd7, 8'h00, 1'b0};
        tbl[12] = '{2'b01, 7'd80, 7'd10,  8'h00, 8'hdf, 8'h08, 1'b0};
        tbl[13] = '{2'b01, 7'd81, 7'd11,  8'h20, 8'hff, 8'h20, 1'b0};
        tbl[14] = '{2'b01, 7'd62, 7'd0,   8'hff, 8'hfb, 8'h00, 1'b0};
        tbl[15] = '{2'b10, 7'd0,  7'd0,   8'hff, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{2'b00, 7'd99, 7'd0,   8'hff, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{2'b11, 7'd5,  7'd5,   8'hff, 8'h00, 8'h00, 1'b0};
        tbl[18] = '{2'b01, 7'd10, 7'd5,   8'hff, 8'h01, 8'h01, 1'b0};

        do_reset();
        for (int i = 0; i < 19; i++)
            run_event($sformatf("tbl%0d", i), tbl[i].t, tbl[i].n, tbl[i].v, tbl[i].idle,
                      1'b1, tbl[i].eg, tbl[i].et, tbl[i].es);

        // Age saturation: voices 1 and 2 both pin at max, lowest index gets stolen.
        do_reset();
        for (int i = 0; i < NV; i++)
            run_event("sat_fill", 2'b01, 7'(60 + i), 7'd64, 8'hff, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int r = 0; r < 250; r++)
            run_event("sat_retrig", 2'b01, 7'd60, 7'(1 + r % 100), 8'hff, 1'b0, 8'h00, 8'h00, 1'b0);
        run_event("sat_steal", 2'b01, 7'd90, 7'd1, 8'hff, 1'b1, 8'hff, 8'h02, 1'b1);

        // Random events against the model.
        do_reset();
        for (int e = 0; e < 150; e++) begin
            int r;
            logic [1:0] t;
            logic [6:0] v;
            r = $urandom_range(0, 19);
            t = (r < 11) ? 2'b01 : (r < 18) ? 2'b00 : (r == 18) ? 2'b10 : 2'b11;
            v = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            run_event("rnd", t, 7'(60 + $urandom_range(0, 11)), v, 8'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
        end

        // Back-to-back: ev_valid held high over three events.
        do_reset();
        env_idle = 8'hff;
        k = 0; cyc = 0; last = 0;
        ev_valid = 1'b1; ev_type = 2'b01; ev_note = 7'd40; ev_vel = 7'd20;
        while (k < 3 && cyc < 100) begin
            acc = ev_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                model_apply(1, 40 + k, 20 + k, 8'hff);
                if (k > 0) chk("b2b_gap", 64'(cyc - last), 64'(NV + 2));
                last = cyc;
                k++;
                if (k < 3) begin
                    ev_note = 7'(40 + k); ev_vel = 7'(20 + k);
                end else begin
                    ev_valid = 1'b0;
                end
            end
        end
        ev_valid = 1'b0;
        chk("b2b_count", 64'(k), 64'd3);
        for (int c = 0; c < NV + 3; c++) begin
            @(posedge clk); #1;
        end
        m_trig = '0;
        check_model("b2b_final");

        // Reset in the middle of a scan drops the event.
        ev_valid = 1'b1; ev_type = 2'b01; ev_note = 7'd50; ev_vel = 7'd33;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midscan_ready_low", 64'(ev_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midscan_ready_high", 64'(ev_ready), 64'd1);
        check_model("midscan_rst");
        for (int c = 0; c < NV + 3; c++) begin
            @(posedge clk); #1;
            chk("midscan_no_trig", 64'(voice_trig), 64'd0);
        end
        check_model("midscan_dropped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
